ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Execute-to-memory pipeline stage of the RV32I core. It sits directly downstream of the `alu` and consumes its result and comparison flags. It resolves conditional branches and jumps, and issues a registered fetch redirect. It latches the surviving instruction into the EX/MEM register under a valid/ready handshake with the memory stage.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `RESET_PC`, 32'h0000_0000: value of `redirect_pc` and `mem_pc` out of reset.

Ports:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-low, `rst_n`.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: EX instruction valid.
- `in_ready` out 1: stage can accept this cycle.
- `in_pc` in XLEN: instruction PC.
- `in_imm` in XLEN: sign-extended immediate.
- `in_funct3` in 3: branch condition / memory size.
- `in_branch`, `in_jal`, `in_jalr` in 1 each: control class (one-hot or none).
- `in_mem_read`, `in_mem_write`, `in_reg_write` in 1 each: downstream controls.
- `in_rd` in 5: destination register.
- `in_rs2_data` in XLEN: store data.
- `alu_out` in XLEN: ALU result (SUB for branches, rs1+imm for JALR/loads/stores).
- `alu_lt`, `alu_ltu`, `zero_flag` in 1 each: ALU flags.
- `mem_valid` out 1: EX/MEM register valid.
- `mem_ready` in 1: memory stage accepts.
- `mem_pc`, `mem_result`, `mem_store_data` out XLEN: registered fields.
- `mem_rd` out 5, `mem_funct3` out 3: registered fields.
- `mem_read`, `mem_write`, `mem_reg_write` out 1 each: registered controls.
- `redirect_valid` out 1: one-cycle fetch redirect pulse.
- `redirect_pc` out XLEN: redirect target.
- `misalign_exc` out 1: one-cycle pulse, taken target not 4-byte aligned.
- `flush` in 1: synchronous kill from trap logic.

## Operation
- Accept occurs when `in_valid && in_ready`, with `in_ready = !mem_valid || mem_ready`.
- Branch taken is decided by funct3:
  - 000 taken if `zero_flag`.
  - 001 taken if `!zero_flag`.
  - 100 taken if `alu_lt`.
  - 101 taken if `!alu_lt`.
  - 110 taken if `alu_ltu`.
  - 111 taken if `!alu_ltu`.
  - 010 and 011 are never taken.
- JAL and JALR are always taken.
- Target:
  - Branch and JAL: `in_pc + in_imm`, modulo 2^XLEN, wrap-around permitted.
  - JALR: `alu_out & ~1`.
- Result:
  - JAL and JALR: `in_pc + 4`.
  - Otherwise: `alu_out`.
- If a taken target has bit 1 set, pulse `misalign_exc` instead of `redirect_valid`. The instruction is still latched with `mem_reg_write` forced to 0.
- FSM has two states:
  - RUN: normal operation. An accepted, aligned, taken instruction sets `redirect_valid`/`redirect_pc` on the next edge and moves to SQUASH.
  - SQUASH: lasts exactly one cycle. `in_ready=1`, and any `in_valid` beat is consumed and discarded (the wrong-path slot). Return to RUN.
- `flush`: clears `mem_valid` and the redirect/exception pulses, and forces RUN. `flush` takes priority over accept and over `mem_ready`.
- When the EX/MEM register holds and `mem_ready=0`, all `mem_*` fields are stable.

## Timing
- EX to EX/MEM latency: 1 cycle.
- EX to `redirect_valid`: 1 cycle, registered.
- `redirect_valid` and `misalign_exc` are high for exactly one cycle per event.
- Reset values:
  - `mem_valid`, `redirect_valid`, `misalign_exc`, and all `mem_*` controls: 0.
  - `mem_pc`, `redirect_pc`: `RESET_PC`.
  - `mem_result`, `mem_store_data`, `mem_rd`, `mem_funct3`: 0.
  - FSM: RUN.
- Reset mid-operation: everything returns asynchronously to the reset values. No redirect fires after `rst_n` deasserts.
- Simultaneous `mem_ready` and accept: the new instruction replaces the old one on the same edge.
- A taken branch accepted while downstream is stalled cannot occur, because `in_ready=0` then. The redirect is issued only on acceptance.
- Back-to-back taken branches: the second one arrives in the SQUASH slot and is discarded.

## Structure
- Shared package `cpu_pkg` holds:
  - funct3 branch codes (`F3_BEQ` … `F3_BGEU`);
  - the FSM state typedef `ex_state_t {RUN, SQUASH}`;
  - `XLEN`.
- One combinational sub-module, `branch_cond`, maps (funct3, zero, lt, ltu) to taken. The remainder is flat.

## Test plan
- BEQ, pc=0x100, imm=0x20, zero_flag=1 -> next cycle `redirect_valid=1`, `redirect_pc=0x120`; the following `in_valid` beat is dropped (`mem_valid` stays 0 for it).
- BLTU with alu_ltu=0 (and BGE with alu_lt=1) -> no redirect; `mem_result` equals `alu_out`; the next instruction is latched normally.
- JALR, pc=0x200, alu_out=0x1235 -> `redirect_pc=0x1234`, `mem_result=0x204`. Then JAL, pc=0x300, imm=0x2 -> `misalign_exc=1`, no redirect, `mem_reg_write=0`.
- `mem_ready` held low for 3 cycles with `in_valid=1` -> `in_ready=0`, `mem_*` fields stable; on release the new instruction is latched on the same edge.
- `flush` asserted in the same cycle as a taken-branch accept -> no redirect, `mem_valid=0`, FSM RUN.
- `rst_n` dropped asynchronously mid-cycle while in SQUASH -> all outputs at reset values immediately; `mem_pc=RESET_PC`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions.
// Branch funct3 codes, EX stage FSM states, datapath width.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    RUN,
    SQUASH
  } ex_state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator.
// Maps funct3 and ALU flags to a taken decision.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_lt,
  input  logic       i_ltu,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    unique case (1'b1)
      (i_funct3 == F3_BEQ):  o_taken = i_zero;
      (i_funct3 == F3_BNE):  o_taken = !i_zero;
      (i_funct3 == F3_BLT):  o_taken = i_lt;
      (i_funct3 == F3_BGE):  o_taken = !i_lt;
      (i_funct3 == F3_BLTU): o_taken = i_ltu;
      (i_funct3 == F3_BGEU): o_taken = !i_ltu;
      default:               o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: branch resolution, fetch redirect,
// and the EX/MEM register under a valid/ready handshake.
module ex_mem_stage #(
  parameter int          XLEN     = cpu_pkg::XLEN,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_funct3,
  input  logic            in_branch,
  input  logic            in_jal,
  input  logic            in_jalr,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_lt,
  input  logic            alu_ltu,
  input  logic            zero_flag,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_pc,
  output logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [4:0]      mem_rd,
  output logic [2:0]      mem_funct3,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_reg_write,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            misalign_exc,
  input  logic            flush
);

  import cpu_pkg::*;

  ex_state_t r_state;
  ex_state_t w_state_nxt;

  logic            r_mem_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_store;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic            r_rd_en;
  logic            r_wr_en;
  logic            r_rw_en;
  logic            r_redir_v;
  logic [XLEN-1:0] r_redir_pc;
  logic            r_mis;

  logic            w_ready;
  logic            w_acc;
  logic            w_cond;
  logic            w_jump;
  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic            w_mis;
  logic            w_redir;
  logic [XLEN-1:0] w_result;

  branch_cond u_cond (
    .i_funct3 (in_funct3),
    .i_zero   (zero_flag),
    .i_lt     (alu_lt),
    .i_ltu    (alu_ltu),
    .o_taken  (w_cond)
  );

  // The SQUASH slot always drains its input beat.
  assign w_ready  = (r_state == SQUASH) || !r_mem_valid
                 || mem_ready;
  assign w_acc    = in_valid && w_ready
                 && (r_state == RUN) && !flush;
  assign w_jump   = in_jal || in_jalr;
  assign w_taken  = w_jump || (in_branch && w_cond);
  assign w_target = in_jalr ? (alu_out & ~XLEN'(1))
                            : (in_pc + in_imm);
  assign w_mis    = w_taken && w_target[1];
  assign w_redir  = w_acc && w_taken && !w_mis;
  assign w_result = w_jump ? (in_pc + XLEN'(4)) : alu_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:     if (w_redir) w_state_nxt = SQUASH;
      SQUASH:  w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
    if (flush) w_state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_valid <= 1'b0;
      r_pc        <= XLEN'(RESET_PC);
      r_result    <= '0;
      r_store     <= '0;
      r_rd        <= '0;
      r_funct3    <= '0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rw_en     <= 1'b0;
      r_redir_v   <= 1'b0;
      r_redir_pc  <= XLEN'(RESET_PC);
      r_mis       <= 1'b0;
    end else begin
      r_redir_v <= w_redir;
      r_mis     <= w_acc && w_mis;
      if (w_redir) r_redir_pc <= w_target;
      if (flush) begin
        r_mem_valid <= 1'b0;
      end else if (w_acc) begin
        r_mem_valid <= 1'b1;
        r_pc        <= in_pc;
        r_result    <= w_result;
        r_store     <= in_rs2_data;
        r_rd        <= in_rd;
        r_funct3    <= in_funct3;
        r_rd_en     <= in_mem_read;
        r_wr_en     <= in_mem_write;
        r_rw_en     <= in_reg_write && !w_mis;
      end else if (mem_ready) begin
        r_mem_valid <= 1'b0;
      end
    end
  end

  assign in_ready       = w_ready;
  assign mem_valid      = r_mem_valid;
  assign mem_pc         = r_pc;
  assign mem_result     = r_result;
  assign mem_store_data = r_store;
  assign mem_rd         = r_rd;
  assign mem_funct3     = r_funct3;
  assign mem_read       = r_rd_en;
  assign mem_write      = r_wr_en;
  assign mem_reg_write  = r_rw_en;
  assign redirect_valid = r_redir_v;
  assign redirect_pc    = r_redir_pc;
  assign misalign_exc   = r_mis;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic [2:0]  in_funct3;
  logic        in_branch;
  logic        in_jal;
  logic        in_jalr;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [31:0] in_rs2_data;
  logic [31:0] alu_out;
  logic        alu_lt;
  logic        alu_ltu;
  logic        zero_flag;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_pc;
  logic [31:0] mem_result;
  logic [31:0] mem_store_data;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
  logic        mem_read;
  logic        mem_write;
  logic        mem_reg_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_exc;
  logic        flush;

  ex_mem_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_funct3(in_funct3), .in_branch(in_branch),
    .in_jal(in_jal), .in_jalr(in_jalr),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_reg_write(in_reg_write), .in_rd(in_rd),
    .in_rs2_data(in_rs2_data), .alu_out(alu_out),
    .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .zero_flag(zero_flag),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_pc(mem_pc), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_funct3(mem_funct3), .mem_read(mem_read),
    .mem_write(mem_write), .mem_reg_write(mem_reg_write),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .misalign_exc(misalign_exc), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source operands behind the ALU result, used by the model.
  logic [31:0] opa, opb;

  // Model of the architecturally visible stage state.
  bit          m_valid;
  logic [31:0] m_pc, m_res, m_st;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  bit          m_rd_en, m_wr_en, m_rw_en;
  bit          m_rv, m_mis;
  logic [31:0] m_rpc;
  bit          m_wrong_path;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic bit br_taken(logic [2:0] f3,
                                  logic [31:0] a,
                                  logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return !($signed(a) < $signed(b));
      3'b110:  return a < b;
      3'b111:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_ready();
    return m_wrong_path || !m_valid || mem_ready;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pc = 0; m_res = 0; m_st = 0;
    m_rd = 0; m_f3 = 0;
    m_rd_en = 0; m_wr_en = 0; m_rw_en = 0;
    m_rv = 0; m_mis = 0; m_rpc = 0;
    m_wrong_path = 0;
  endtask

  task automatic model_step();
    bit tk, jump, ready;
    logic [31:0] tgt;
    ready = m_ready();
    m_rv  = 0;
    m_mis = 0;
    if (flush) begin
      m_valid      = 0;
      m_wrong_path = 0;
    end else if (m_wrong_path) begin
      m_wrong_path = 0;
      if (mem_ready) m_valid = 0;
    end else if (in_valid && ready) begin
      jump = in_jal || in_jalr;
      tk   = jump || (in_branch && br_taken(in_funct3, opa, opb));
      tgt  = in_jalr ? ((opa + in_imm) & 32'hFFFF_FFFE)
                     : (in_pc + in_imm);
      m_valid = 1;
      m_pc    = in_pc;
      m_res   = jump ? in_pc + 32'd4 : alu_out;
      m_st    = in_rs2_data;
      m_rd    = in_rd;
      m_f3    = in_funct3;
      m_rd_en = in_mem_read;
      m_wr_en = in_mem_write;
      m_rw_en = in_reg_write;
      if (tk && tgt[1]) begin
        m_mis   = 1;
        m_rw_en = 0;
      end else if (tk) begin
        m_rv  = 1;
        m_rpc = tgt;
        m_wrong_path = 1;
      end
    end else if (mem_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check_outputs();
    chk("mem_valid", 32'(mem_valid), 32'(m_valid));
    chk("mem_pc", mem_pc, m_pc);
    chk("mem_result", mem_result, m_res);
    chk("mem_store_data", mem_store_data, m_st);
    chk("mem_rd", 32'(mem_rd), 32'(m_rd));
    chk("mem_funct3", 32'(mem_funct3), 32'(m_f3));
    chk("mem_read", 32'(mem_read), 32'(m_rd_en));
    chk("mem_write", 32'(mem_write), 32'(m_wr_en));
    chk("mem_reg_write", 32'(mem_reg_write), 32'(m_rw_en));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("misalign_exc", 32'(misalign_exc), 32'(m_mis));
  endtask

  task automatic tick();
    #1;
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clr_in();
    in_valid = 0; in_pc = 0; in_imm = 0; in_funct3 = 0;
    in_branch = 0; in_jal = 0; in_jalr = 0;
    in_mem_read = 0; in_mem_write = 0; in_reg_write = 0;
    in_rd = 0; in_rs2_data = 0; alu_out = 0;
    alu_lt = 0; alu_ltu = 0; zero_flag = 0;
    opa = 0; opb = 0;
  endtask

  task automatic set_br(logic [31:0] pc, logic [31:0] imm,
                        logic [2:0] f3, logic [31:0] a,
                        logic [31:0] b);
    clr_in();
    in_valid = 1; in_branch = 1;
    in_pc = pc; in_imm = imm; in_funct3 = f3;
    in_rs2_data = b; opa = a; opb = b;
    alu_out   = a - b;
    zero_flag = (a == b);
    alu_lt    = $signed(a) < $signed(b);
    alu_ltu   = a < b;
  endtask

  task automatic set_jal(logic [31:0] pc, logic [31:0] imm,
                         logic [4:0] rd);
    clr_in();
    in_valid = 1; in_jal = 1; in_reg_write = 1;
    in_pc = pc; in_imm = imm; in_rd = rd;
    alu_out = $urandom;
  endtask

  task automatic set_jalr(logic [31:0] pc, logic [31:0] rs1,
                          logic [31:0] imm, logic [4:0] rd);
    clr_in();
    in_valid = 1; in_jalr = 1; in_reg_write = 1;
    in_pc = pc; in_imm = imm; in_rd = rd;
    opa = rs1; alu_out = rs1 + imm;
  endtask

  task automatic set_alu(logic [31:0] pc, logic [31:0] res,
                         logic [4:0] rd);
    clr_in();
    in_valid = 1; in_pc = pc; alu_out = res; in_rd = rd;
    in_funct3    = 3'($urandom);
    in_mem_read  = 1'($urandom);
    in_mem_write = 1'($urandom);
    in_reg_write = 1'($urandom);
    in_rs2_data  = $urandom;
    alu_lt = 1'($urandom); alu_ltu = 1'($urandom);
    zero_flag = 1'($urandom);
  endtask

  initial begin
    int kind;
    logic [31:0] pc, imm;
    clr_in();
    rst_n = 0; mem_ready = 1; flush = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1;

    // Taken BEQ, then the wrong-path beat is dropped.
    set_br(32'h100, 32'h20, 3'b000, 32'd5, 32'd5);
    tick();
    chk("beq_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("beq_redirect_pc", redirect_pc, 32'h120);
    set_alu(32'h104, 32'hDEAD, 5'd3);
    tick();
    chk("beq_slot_dropped", 32'(mem_valid), 32'd0);

    // BLTU and BGE not taken; the following beat is latched.
    set_br(32'h140, 32'h40, 3'b110, 32'd10, 32'd3);
    tick();
    chk("bltu_no_redirect", 32'(redirect_valid), 32'd0);
    chk("bltu_result", mem_result, 32'd7);
    set_br(32'h144, 32'h40, 3'b101, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk("bge_no_redirect", 32'(redirect_valid), 32'd0);
    set_alu(32'h148, 32'h55, 5'd4);
    tick();
    chk("after_bge_valid", 32'(mem_valid), 32'd1);
    chk("after_bge_pc", mem_pc, 32'h148);

    // JALR with odd target, then a misaligned JAL.
    set_jalr(32'h200, 32'h1235, 32'h0, 5'd1);
    tick();
    chk("jalr_redirect_pc", redirect_pc, 32'h1234);
    chk("jalr_result", mem_result, 32'h204);
    clr_in();
    tick();
    set_jal(32'h300, 32'h2, 5'd1);
    tick();
    chk("jal_misalign", 32'(misalign_exc), 32'd1);
    chk("jal_no_redirect", 32'(redirect_valid), 32'd0);
    chk("jal_no_regwrite", 32'(mem_reg_write), 32'd0);
    clr_in();
    tick();
    chk("misalign_pulse", 32'(misalign_exc), 32'd0);

    // Downstream stall for 3 cycles.
    set_alu(32'h400, 32'h1111, 5'd5);
    tick();
    mem_ready = 0;
    set_alu(32'h404, 32'h2222, 5'd6);
    repeat (3) begin
      tick();
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_hold_pc", mem_pc, 32'h400);
    end
    mem_ready = 1;
    tick();
    chk("release_pc", mem_pc, 32'h404);
    chk("release_result", mem_result, 32'h2222);

    // Flush beats a taken-branch accept.
    set_br(32'h500, 32'h10, 3'b001, 32'd1, 32'd2);
    flush = 1;
    tick();
    flush = 0;
    chk("flush_no_redirect", 32'(redirect_valid), 32'd0);
    chk("flush_mem_valid", 32'(mem_valid), 32'd0);
    set_alu(32'h600, 32'h77, 5'd7);
    tick();
    chk("flush_run_accept", 32'(mem_valid), 32'd1);

    // Async reset while in SQUASH.
    set_br(32'h700, 32'h8, 3'b000, 32'd9, 32'd9);
    tick();
    clr_in();
    #2 rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_mem_pc", mem_pc, 32'h0);
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("post_rst_no_redirect", 32'(redirect_valid), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      mem_ready = ($urandom_range(9) < 7);
      flush     = ($urandom_range(19) == 0);
      pc  = $urandom & 32'hFFFF_FFFC;
      imm = ($urandom & 32'hFFFF_FFFC)
          | ($urandom_range(3) == 0 ? 32'h2 : 32'h0);
      kind = $urandom_range(3);
      case (kind)
        0: set_br(pc, imm, 3'($urandom),
                  ($urandom_range(3) == 0) ? 32'd42 : $urandom,
                  ($urandom_range(3) == 0) ? 32'd42 : $urandom);
        1: set_jal(pc, imm, 5'($urandom));
        2: set_jalr(pc, $urandom, $urandom, 5'($urandom));
        default: set_alu(pc, $urandom, 5'($urandom));
      endcase
      in_valid = ($urandom_range(9) < 8);
      tick();
    end
    flush = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
